// File: rtl/multiples_fifo_ctrl.sv
// Sequencing controller for the 10-entry multiples FIFO: pointers, occupancy,
// valid/ready handshakes and a run/drain state machine around an external storage array.
module multiples_fifo_ctrl #(
    parameter int DEPTH                        = 10,
    parameter int multiples_memory_value_width = 3
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic                                    drain_req,
    input  logic                                    in_valid,
    input  logic [multiples_memory_value_width-1:0] in_data,
    output logic                                    in_ready,
    output logic                                    out_valid,
    output logic [multiples_memory_value_width-1:0] out_data,
    input  logic                                    out_ready,
    output logic                                    fifo_write_enable,
    output logic [3:0]                              fifo_write_address,
    output logic [3:0]                              fifo_read_address,
    output logic [multiples_memory_value_width-1:0] fifo_input_data,
    input  logic [multiples_memory_value_width-1:0] fifo_output_data,
    output logic [3:0]                              count,
    output logic                                    full,
    output logic                                    empty,
    output logic                                    busy,
    output logic                                    drain_done,
    output logic                                    overflow_err,
    output logic                                    underflow_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [3:0] count_next;
    logic       push;
    logic       pop;

    assign full      = (count == 4'(DEPTH));
    assign empty     = (count == 4'd0);
    assign busy      = (state != IDLE);
    assign in_ready  = (state == RUN) && !full;
    assign out_valid = (state != IDLE) && !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // The array writes slot (address - 1), so the address leads wr_ptr by one.
    assign fifo_write_enable  = push;
    assign fifo_write_address = wr_ptr + 4'd1;
    assign fifo_read_address  = rd_ptr;
    assign fifo_input_data    = in_data;
    assign out_data           = fifo_output_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 4'd1;
            2'b01:   count_next = count - 4'd1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (drain_req) state_next = DRAIN;
            // Looks at the post-edge count so the edge of the last pop also ends the drain.
            DRAIN:   if (count_next == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= 4'd0;
            rd_ptr        <= 4'd0;
            count         <= 4'd0;
            drain_done    <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            drain_done <= (state == DRAIN) && (state_next == IDLE);
            if (push)
                wr_ptr <= (wr_ptr == 4'(DEPTH - 1)) ? 4'd0 : wr_ptr + 4'd1;
            if (pop)
                rd_ptr <= (rd_ptr == 4'(DEPTH - 1)) ? 4'd0 : rd_ptr + 4'd1;
            if (in_valid && !in_ready && (state == RUN))
                overflow_err <= 1'b1;
            if (out_ready && !out_valid && (state != IDLE))
                underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multiples_fifo_ctrl.sv
// Directed bench for multiples_fifo_ctrl with a behavioural 10-entry storage array
// (registered write to slot address-1, combinational read).
module tb_multiples_fifo_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       drain_req;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_ready;
    logic       fifo_write_enable;
    logic [3:0] fifo_write_address;
    logic [3:0] fifo_read_address;
    logic [2:0] fifo_input_data;
    logic [2:0] fifo_output_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       busy;
    logic       drain_done;
    logic       overflow_err;
    logic       underflow_err;

    int total = 0;
    int bad   = 0;

    multiples_fifo_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .drain_req          (drain_req),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .out_ready          (out_ready),
        .fifo_write_enable  (fifo_write_enable),
        .fifo_write_address (fifo_write_address),
        .fifo_read_address  (fifo_read_address),
        .fifo_input_data    (fifo_input_data),
        .fifo_output_data   (fifo_output_data),
        .count              (count),
        .full               (full),
        .empty              (empty),
        .busy               (busy),
        .drain_done         (drain_done),
        .overflow_err       (overflow_err),
        .underflow_err      (underflow_err)
    );

    // Storage array model.
    logic [2:0] mem [10];
    initial for (int i = 0; i < 10; i++) mem[i] = 3'd0;
    always @(posedge clk)
        if (fifo_write_enable && fifo_write_address >= 4'd1 && fifo_write_address <= 4'd10)
            mem[int'(fifo_write_address) - 1] <= fifo_input_data;
    assign fifo_output_data = (fifo_read_address < 4'd10) ? mem[fifo_read_address] : 3'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       drain;
        logic       iv;
        logic [2:0] id;
        logic       ordy;
        int         e_count;
        logic       e_in_ready;
        logic       e_out_valid;
        logic [2:0] e_out_data;
        logic       e_we;
        int         e_waddr;
        int         e_raddr;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; one rising edge is consumed per step.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic d, input logic iv, input logic [2:0] id, input logic ordy);
        start     = s;
        drain_req = d;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_we", int'(fifo_write_enable), 0);
        check("rst_waddr", int'(fifo_write_address), 1);
        check("rst_raddr", int'(fifo_read_address), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drain_done", int'(drain_done), 0);
        check("rst_errs", int'({overflow_err, underflow_err}), 0);

        // Start, then push 3,5,7 with the consumer stalled
        //               st    dr    iv    id    ordy  cnt  ir    ov    od    we    wa  ra
        vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 0, 1'b1, 1'b0, 3'd0, 1'b1, 1, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1, 1'b1, 1'b1, 3'd3, 1'b1, 2, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 2, 1'b1, 1'b1, 3'd3, 1'b1, 3, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3, 1'b1, 1'b1, 3'd3, 1'b0, 4, 0};
        for (int v = 0; v < 5; v++) begin
            drive(vecs[v].start, vecs[v].drain, vecs[v].iv, vecs[v].id, vecs[v].ordy);
            check($sformatf("v%0d_count", v), int'(count), vecs[v].e_count);
            check($sformatf("v%0d_in_ready", v), int'(in_ready), int'(vecs[v].e_in_ready));
            check($sformatf("v%0d_out_valid", v), int'(out_valid), int'(vecs[v].e_out_valid));
            if (vecs[v].e_out_valid)
                check($sformatf("v%0d_out_data", v), int'(out_data), int'(vecs[v].e_out_data));
            check($sformatf("v%0d_we", v), int'(fifo_write_enable), int'(vecs[v].e_we));
            check($sformatf("v%0d_waddr", v), int'(fifo_write_address), vecs[v].e_waddr);
            check($sformatf("v%0d_raddr", v), int'(fifo_read_address), vecs[v].e_raddr);
            step();
        end

        // Fill to 10 with values 0..7,0,1, then overflow
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 3'(i % 8), 1'b0);
            check($sformatf("fill%0d_in_ready", i), int'(in_ready), 1);
            check($sformatf("fill%0d_waddr", i), int'(fifo_write_address), i + 1);
            check($sformatf("fill%0d_count", i), int'(count), i);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("full_flag", int'(full), 1);
        check("full_count", int'(count), 10);
        check("full_in_ready", int'(in_ready), 0);
        check("full_no_ovf_yet", int'(overflow_err), 0);
        drive(1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
        check("ovf_we", int'(fifo_write_enable), 0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("ovf_err", int'(overflow_err), 1);
        check("ovf_count", int'(count), 10);
        check("ovf_waddr", int'(fifo_write_address), 1);

        // Drain all 10 in order, then underflow
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
            check($sformatf("pop%0d_valid", i), int'(out_valid), 1);
            check($sformatf("pop%0d_data", i), int'(out_data), i % 8);
            check($sformatf("pop%0d_raddr", i), int'(fifo_read_address), i);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("emp_flag", int'(empty), 1);
        check("emp_raddr_wrap", int'(fifo_read_address), 0);
        check("emp_out_valid", int'(out_valid), 0);
        check("emp_no_udf_yet", int'(underflow_err), 0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("udf_err", int'(underflow_err), 1);
        check("udf_count", int'(count), 0);
        check("udf_raddr", int'(fifo_read_address), 0);

        // Stream j carries value (j+1)%8: load 4, then 12 cycles of push+pop
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 1'b0, 1'b1, 3'((j + 1) % 8), 1'b0);
            step();
        end
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b0, 1'b1, 3'((k + 5) % 8), 1'b1);
            check($sformatf("pp%0d_count", k), int'(count), 4);
            check($sformatf("pp%0d_data", k), int'(out_data), (k + 1) % 8);
            check($sformatf("pp%0d_waddr", k), int'(fifo_write_address), ((4 + k) % 10) + 1);
            check($sformatf("pp%0d_raddr", k), int'(fifo_read_address), k % 10);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("pp_end_count", int'(count), 4);
        check("pp_end_raddr", int'(fifo_read_address), 2);
        check("pp_end_waddr", int'(fifo_write_address), 7);

        // Pop to 2, then drain (start and drain_req together: drain wins)
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        check("pre_drain_data0", int'(out_data), 5);
        step();
        check("pre_drain_data1", int'(out_data), 6);
        step();
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        check("drn_in_ready", int'(in_ready), 0);
        check("drn_we", int'(fifo_write_enable), 0);
        check("drn_busy", int'(busy), 1);
        check("drn_count", int'(count), 2);
        check("drn_out_data", int'(out_data), 7);
        step();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        check("drn_count_hold", int'(count), 2);
        check("drn_pop0", int'(out_data), 7);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        check("drn_pop1", int'(out_data), 0);
        check("drn_still_busy", int'(busy), 1);
        check("drn_no_done_yet", int'(drain_done), 0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("done_pulse", int'(drain_done), 1);
        check("done_busy", int'(busy), 0);
        check("done_count", int'(count), 0);
        check("done_out_valid", int'(out_valid), 0);
        step();
        check("done_pulse_end", int'(drain_done), 0);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("idle_ignores_drain", int'(busy), 0);

        // Reset mid-run with 6 entries
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("mid_count", int'(count), 6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("mrst_count", int'(count), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_empty", int'(empty), 1);
        check("mrst_out_valid", int'(out_valid), 0);
        check("mrst_errs", int'({overflow_err, underflow_err}), 0);
        check("mrst_waddr", int'(fifo_write_address), 1);
        check("mrst_raddr", int'(fifo_read_address), 0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
        check("post_we", int'(fifo_write_enable), 1);
        check("post_waddr", int'(fifo_write_address), 1);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("post_count", int'(count), 1);
        check("post_data", int'(out_data), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiples_fifo_ctrl.md
Name: multiples_fifo_ctrl

Overview:
- Sequencing controller for the 10-entry multiples FIFO storage array (combinational read, registered write, write slot = write address minus one, modulo 10).
- Owns the read and write pointers, occupancy count, full/empty flags and the producer/consumer valid/ready handshakes.
- Provides a run/drain state machine so the upstream multiples generator can be started and the buffer emptied cleanly.
- Sits between the multiples generator (producer) and the partial-product selector (consumer).

Parameters:
- DEPTH, 10, number of storage slots; pointers wrap modulo DEPTH.
- multiples_memory_value_width, 3, data width passed through to and from the storage array.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle pulse; moves IDLE to RUN.
- drain_req, input, 1, single-cycle pulse; moves RUN to DRAIN.
- in_valid, input, 1, producer has data.
- in_data, input, multiples_memory_value_width, producer data.
- in_ready, output, 1, controller accepts data this cycle.
- out_valid, output, 1, head entry available.
- out_data, output, multiples_memory_value_width, head entry; equals fifo_output_data.
- out_ready, input, 1, consumer takes head this cycle.
- fifo_write_enable, output, 1, to storage array.
- fifo_write_address, output, 4, to storage array; driven as wr_ptr+1, range 1..10.
- fifo_read_address, output, 4, to storage array; equals rd_ptr.
- fifo_input_data, output, multiples_memory_value_width, equals in_data.
- fifo_output_data, input, multiples_memory_value_width, from storage array.
- count, output, 4, occupancy, 0..DEPTH.
- full, output, 1, count==DEPTH.
- empty, output, 1, count==0.
- busy, output, 1, state != IDLE.
- drain_done, output, 1, one-cycle pulse on the DRAIN to IDLE transition.
- overflow_err, output, 1, sticky; set when in_valid is high, in_ready is low and state==RUN.
- underflow_err, output, 1, sticky; set when out_ready is high and out_valid is low and state != IDLE.

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, wr_ptr=0, rd_ptr=0, count=0, errors=0, drain_done=0.
  - After reset: empty=1, full=0, in_ready=0, out_valid=0, fifo_write_enable=0, fifo_write_address=1, fifo_read_address=0.
  - Reset mid-operation discards all contents; storage array contents are not cleared but are unreachable.
- States:
  - IDLE: start goes to RUN; drain_req is ignored.
  - RUN: drain_req goes to DRAIN. If start and drain_req arrive together, drain_req wins.
  - DRAIN: goes to IDLE when count==0 at the clock edge (including the edge of the last pop); start is ignored.
- Handshakes:
  - in_ready = (state==RUN) and not full. There is no full-with-pop bypass.
  - out_valid = not empty, in RUN or DRAIN; out_valid=0 in IDLE. Entries left from an aborted drain are impossible because DRAIN always completes.
  - push = in_valid and in_ready. pop = out_valid and out_ready.
- Storage interface:
  - fifo_write_enable = push (combinational).
  - fifo_write_address = wr_ptr+1, so the array stores at slot wr_ptr. For wr_ptr=9 the address is 10.
  - Pointer wrap: ptr becomes 0 when ptr==DEPTH-1, otherwise ptr+1. wr_ptr advances on push, rd_ptr on pop.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 in cycle N+1. A push into an empty buffer cannot pop in the same cycle.
- drain_done is registered: high for exactly the cycle following the DRAIN to IDLE edge.
- Error flags are cleared only by reset. Neither error condition alters pointers or count.

Test Plan:
- Reset then start; push 3,5,7 on consecutive cycles with out_ready=0 → write addresses 1,2,3; count=3; out_data=3 with out_valid=1 one cycle after the first push.
- Push 10 words (values 0..7,0,1) → full=1, in_ready=0, count=10, last write address=10. Then hold in_valid=1 one more cycle → overflow_err=1, count stays 10.
- Pop all 10 words → output order 0..7,0,1; rd_ptr wraps 9 to 0; empty=1. Then assert out_ready again → underflow_err=1.
- With count=4, push and pop together for 12 cycles → count stays 4, both pointers wrap, data order preserved.
- With count=2, pulse drain_req, then in_valid=1 → in_ready=0 and no writes. Pop 2 → IDLE entered; drain_done pulses one cycle; busy=0.
- Assert reset with count=6 in RUN → next cycle count=0, state=IDLE, all flags at reset values. Then start and push 1 → write address 1.
